// File: rtl/cam_ctrl_if.sv
// Request/response handshake bundle between a request source and cam_ctrl.
// The master side issues requests and consumes responses; the slave side is
// the controller.
interface cam_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 3
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [WIDTH-1:0] req_data_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_write_o;
  logic             resp_hit_o;
  logic [IDXW-1:0]  resp_index_o;
  logic             resp_replaced_o;

  modport master (
    output req_valid_i, req_write_i, req_data_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_write_o, resp_hit_o,
           resp_index_o, resp_replaced_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_data_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_write_o, resp_hit_o,
           resp_index_o, resp_replaced_o
  );
endinterface

// File: rtl/cam_ctrl.sv
// Front-end controller for a row-organised CAM. One request is in flight at a
// time: a write lands in the lowest free row (or the round-robin victim when
// the array is full); a lookup strobes all rows and priority-encodes the
// lowest valid matching row. All outputs come straight from flops.
module cam_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ROWS      = 8,
  parameter int IDXW      = $clog2(ROWS),
  parameter int MATCH_LAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  cam_ctrl_if.slave        bus,
  output logic [ROWS-1:0]  row_write_enable_o,
  output logic [WIDTH-1:0] row_data_o,
  output logic             row_compare_enable_o,
  output logic [WIDTH-1:0] row_compare_o,
  input  logic [ROWS-1:0]  row_match_i,
  input  logic [ROWS-1:0]  row_valid_i
);

  localparam int CW = (MATCH_LAT > 0) ? $clog2(MATCH_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    COMPARE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [IDXW-1:0]  tgt_q, tgt_d;
  logic             repl_q, repl_d;
  logic [IDXW-1:0]  victim_q, victim_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROWS-1:0]  we_q, we_d;
  logic [WIDTH-1:0] row_data_q, row_data_d;
  logic             cmp_en_q, cmp_en_d;
  logic [WIDTH-1:0] cmp_key_q, cmp_key_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_write_q, resp_write_d;
  logic             resp_hit_q, resp_hit_d;
  logic [IDXW-1:0]  resp_index_q, resp_index_d;
  logic             resp_replaced_q, resp_replaced_d;

  logic [IDXW:0]    free_s;
  logic [IDXW:0]    hit_s;

  // Lowest set bit of vec: {found, index}; index is 0 when nothing is set.
  function automatic logic [IDXW:0] find_first(input logic [ROWS-1:0] vec);
    logic [IDXW:0] res;
    res = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, IDXW'(i)};
      end
    end
    return res;
  endfunction

  // Free-row and hit priority encoders over the live row status.
  always_comb begin
    free_s = find_first(~row_valid_i);
    hit_s  = find_first(row_match_i & row_valid_i);
  end

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d         = state_q;
    ready_d         = 1'b0;
    tgt_d           = tgt_q;
    repl_d          = repl_q;
    victim_d        = victim_q;
    cnt_d           = cnt_q;
    we_d            = '0;
    row_data_d      = row_data_q;
    cmp_en_d        = 1'b0;
    cmp_key_d       = cmp_key_q;
    resp_valid_d    = resp_valid_q;
    resp_write_d    = resp_write_q;
    resp_hit_d      = resp_hit_q;
    resp_index_d    = resp_index_q;
    resp_replaced_d = resp_replaced_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i && ready_q) begin
          if (bus.req_write_i) begin
            // Row status cannot change before the write cycle, so the target
            // is chosen here and the enable leaves a flop in WRITE.
            state_d    = WRITE;
            row_data_d = bus.req_data_i;
            if (free_s[IDXW]) begin
              tgt_d  = free_s[IDXW-1:0];
              repl_d = 1'b0;
            end else begin
              tgt_d  = victim_q;
              repl_d = 1'b1;
            end
            we_d = {{(ROWS-1){1'b0}}, 1'b1} << tgt_d;
          end else begin
            state_d   = COMPARE;
            cmp_key_d = bus.req_data_i;
            cmp_en_d  = 1'b1;
            cnt_d     = '0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      WRITE: begin
        if (repl_q) begin
          victim_d = (victim_q == IDXW'(ROWS - 1)) ? '0 : victim_q + IDXW'(1);
        end else begin
          victim_d = victim_q;
        end
        state_d         = RESP;
        resp_valid_d    = 1'b1;
        resp_write_d    = 1'b1;
        resp_hit_d      = 1'b0;
        resp_index_d    = tgt_q;
        resp_replaced_d = repl_q;
      end
      COMPARE: begin
        if (cnt_q == CW'(MATCH_LAT)) begin
          state_d         = RESP;
          resp_valid_d    = 1'b1;
          resp_write_d    = 1'b0;
          resp_hit_d      = hit_s[IDXW];
          resp_index_d    = hit_s[IDXW-1:0];
          resp_replaced_d = 1'b0;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          cmp_en_d = 1'b1;
        end
      end
      RESP: begin
        if (resp_valid_q && bus.resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          ready_d      = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight work at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ready_q         <= 1'b0;
      tgt_q           <= '0;
      repl_q          <= 1'b0;
      victim_q        <= '0;
      cnt_q           <= '0;
      we_q            <= '0;
      row_data_q      <= '0;
      cmp_en_q        <= 1'b0;
      cmp_key_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_write_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_index_q    <= '0;
      resp_replaced_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ready_q         <= ready_d;
      tgt_q           <= tgt_d;
      repl_q          <= repl_d;
      victim_q        <= victim_d;
      cnt_q           <= cnt_d;
      we_q            <= we_d;
      row_data_q      <= row_data_d;
      cmp_en_q        <= cmp_en_d;
      cmp_key_q       <= cmp_key_d;
      resp_valid_q    <= resp_valid_d;
      resp_write_q    <= resp_write_d;
      resp_hit_q      <= resp_hit_d;
      resp_index_q    <= resp_index_d;
      resp_replaced_q <= resp_replaced_d;
    end
  end

  assign bus.req_ready_o     = ready_q;
  assign bus.resp_valid_o    = resp_valid_q;
  assign bus.resp_write_o    = resp_write_q;
  assign bus.resp_hit_o      = resp_hit_q;
  assign bus.resp_index_o    = resp_index_q;
  assign bus.resp_replaced_o = resp_replaced_q;
  assign row_write_enable_o  = we_q;
  assign row_data_o          = row_data_q;
  assign row_compare_enable_o = cmp_en_q;
  assign row_compare_o       = cmp_key_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: a behavioural row array answers the
// controller, and a reference model of the CAM contents predicts every
// response from the allocation and priority rules.
module tb_cam_ctrl;
  localparam int W  = 32;
  localparam int R  = 8;
  localparam int IW = 3;
  localparam int ML = 2;

  logic          clk;
  logic          reset_n;
  logic [R-1:0]  row_we;
  logic [W-1:0]  row_data;
  logic          row_cmp_en;
  logic [W-1:0]  row_cmp;
  logic [R-1:0]  row_match;
  logic [R-1:0]  row_valid;

  cam_ctrl_if #(.WIDTH(W), .IDXW(IW)) bus ();

  cam_ctrl #(.WIDTH(W), .ROWS(R), .IDXW(IW), .MATCH_LAT(ML)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bus                 (bus),
    .row_write_enable_o  (row_we),
    .row_data_o          (row_data),
    .row_compare_enable_o(row_cmp_en),
    .row_compare_o       (row_cmp),
    .row_match_i         (row_match),
    .row_valid_i         (row_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural row array (environment) ----------------
  logic [W-1:0] env_mem [R];
  logic [R-1:0] env_vld;
  logic         env_clr;
  logic [R-1:0] vmask;
  logic         pv0, pv1;
  logic [W-1:0] pk0, pk1;

  // Rows store written data; the compare strobe reaches the match outputs ML cycles later.
  always @(posedge clk) begin
    pv0 <= row_cmp_en;
    pk0 <= row_cmp;
    pv1 <= pv0;
    pk1 <= pk0;
    if (env_clr) begin
      env_vld <= '0;
    end else begin
      for (int i = 0; i < R; i++) begin
        if (row_we[i]) begin
          env_mem[i] <= row_data;
          env_vld[i] <= 1'b1;
        end
      end
    end
  end

  // Match ignores the valid flag on purpose so stale rows look like matches.
  always_comb begin
    row_match = '0;
    for (int i = 0; i < R; i++) row_match[i] = pv1 && (env_mem[i] == pk1);
  end
  assign row_valid = env_vld & ~vmask;

  // ---------------- reference model ----------------
  logic [W-1:0] ref_mem [R];
  logic [R-1:0] ref_vld;
  int           ref_victim;

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [W-1:0] d, output int idx, output logic rep);
    idx = -1;
    for (int i = 0; i < R; i++) if (idx < 0 && !ref_vld[i]) idx = i;
    if (idx < 0) begin
      idx = ref_victim;
      rep = 1'b1;
      ref_victim = (ref_victim + 1) % R;
    end else begin
      rep = 1'b0;
    end
    ref_mem[idx] = d;
    ref_vld[idx] = 1'b1;
  endtask

  task automatic ref_lookup(input logic [W-1:0] k, output logic hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < R; i++) begin
      if (!hit && ref_vld[i] && !vmask[i] && ref_mem[i] == k) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, bus.req_ready_o, 0);
    check({tag, "_rvalid"}, bus.resp_valid_o, 0);
    check({tag, "_rwrite"}, bus.resp_write_o, 0);
    check({tag, "_rhit"}, bus.resp_hit_o, 0);
    check({tag, "_ridx"}, bus.resp_index_o, 0);
    check({tag, "_rrepl"}, bus.resp_replaced_o, 0);
    check({tag, "_we"}, row_we, 0);
    check({tag, "_rdata"}, row_data, 0);
    check({tag, "_cmpen"}, row_cmp_en, 0);
    check({tag, "_cmp"}, row_cmp, 0);
  endtask

  task automatic clear_all();
    env_clr = 1'b1;
    @(posedge clk);
    #1 env_clr = 1'b0;
    ref_vld = '0;
    ref_victim = 0;
    vmask = '0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    clear_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One request with full latency, row-signal, response and back-pressure checks.
  task automatic do_req(input logic wr, input logic [W-1:0] d, input int hold);
    logic         exp_hit, exp_rep, seen;
    int           exp_idx, k, guard, lat;
    logic [R-1:0] exp_we;
    if (wr) begin
      ref_write(d, exp_idx, exp_rep);
      exp_hit = 1'b0;
    end else begin
      ref_lookup(d, exp_hit, exp_idx);
      exp_rep = 1'b0;
    end
    exp_we = '0;
    exp_we[exp_idx] = 1'b1;
    lat = wr ? 2 : 2 + ML;

    guard = 0;
    @(negedge clk);
    while (!bus.req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready", bus.req_ready_o, 1);
    bus.req_valid_i  = 1'b1;
    bus.req_write_i  = wr;
    bus.req_data_i   = d;
    bus.resp_ready_i = (hold == 0);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    bus.req_data_i = $urandom;

    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.resp_valid_o) begin
        seen = 1'b1;
      end else if (wr) begin
        check("wr_we", row_we, (k == 1) ? exp_we : '0);
        if (k == 1) check("wr_data", row_data, d);
        check("wr_cmpen", row_cmp_en, 0);
      end else begin
        check("lk_cmpen", row_cmp_en, (k <= ML + 1) ? 1 : 0);
        if (k <= ML + 1) check("lk_key", row_cmp, d);
        check("lk_we", row_we, 0);
      end
    end
    check("latency", k, lat);
    check("resp_write", bus.resp_write_o, wr);
    check("resp_hit", bus.resp_hit_o, exp_hit);
    check("resp_index", bus.resp_index_o, exp_idx);
    check("resp_repl", bus.resp_replaced_o, exp_rep);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", bus.resp_valid_o, 1);
      check("bp_hit", bus.resp_hit_o, exp_hit);
      check("bp_index", bus.resp_index_o, exp_idx);
      check("bp_ready", bus.req_ready_o, 0);
      check("bp_rowen", {row_we, row_cmp_en}, 0);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", bus.resp_valid_o, 0);
    check("post_ready", bus.req_ready_o, 1);
  endtask

  initial begin
    logic [W-1:0] key;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    env_clr = 1'b0;
    vmask = '0;
    env_vld = '0;
    pv0 = 1'b0; pv1 = 1'b0; pk0 = '0; pk1 = '0;
    for (int i = 0; i < R; i++) env_mem[i] = '0;
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_data_i = '0;
    bus.resp_ready_i = 1'b1;

    // Reset state and first write.
    do_reset();
    do_req(1'b1, 32'hDEAD_BEEF, 0);

    // Fill all rows, hit and miss lookups.
    do_reset();
    for (int i = 0; i < R; i++) do_req(1'b1, 32'h10 + W'(i), 0);
    do_req(1'b0, 32'h15, 0);
    do_req(1'b0, 32'h99, 0);

    // Replacement on a full array: eleven writes wrap the victim pointer.
    for (int i = 0; i < 11; i++) do_req(1'b1, 32'h100 + W'(i), 0);
    check("victim_wrap", ref_victim, 3);
    do_req(1'b0, 32'h10A, 0);

    // Duplicate keys and an invalid row that still reports a match.
    do_reset();
    do_req(1'b1, 32'h01, 0);
    do_req(1'b1, 32'h02, 0);
    do_req(1'b1, 32'hAA, 0);
    do_req(1'b1, 32'h03, 0);
    do_req(1'b1, 32'h04, 0);
    do_req(1'b1, 32'h05, 0);
    do_req(1'b1, 32'hAA, 0);
    do_req(1'b1, 32'h06, 0);
    do_req(1'b0, 32'hAA, 0);
    vmask = 8'b0000_0100;
    do_req(1'b0, 32'hAA, 0);
    vmask = '0;

    // Long back-pressure on a lookup and on a write.
    do_req(1'b0, 32'h05, 10);
    do_req(1'b1, 32'h55, 10);

    // Reset in the middle of a compare.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_data_i = 32'h04;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("midcmp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midcmp_noresp", bus.resp_valid_o, 0);
    end
    clear_all();
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b1, 32'h77, 0);
    do_req(1'b0, 32'h03, 0);

    // Random mix from a small key pool; stale rows keep matching but are invalid.
    for (int n = 0; n < 80; n++) begin
      key = 32'h200 + W'($urandom_range(0, 11));
      do_req(1'($urandom_range(0, 1)), key, ($urandom_range(0, 5) == 0) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Front-end controller for an array of ROWS CAM rows, each WIDTH bits wide.
- Accepts write and lookup requests over a valid/ready handshake and drives the rows' per-row write enables, shared write data, compare enable and compare key.
- Collects the rows' match and valid vectors, then returns one response per request over a valid/ready handshake: hit flag, priority-encoded row index and a replacement flag.
- Sits between the request source and the row array.

Parameters:
- WIDTH, 32, key/data width per row.
- ROWS, 8, number of rows driven; must be at least 2.
- IDXW, $clog2(ROWS), width of the row index.
- MATCH_LAT, 0, cycles from compare_enable_o assertion until match_i is valid (0 means same cycle).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_write_i  in  1  1 = write, 0 = lookup.
- req_data_i  in  WIDTH  write data or lookup key.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- resp_write_o  out  1  echo of the request type.
- resp_hit_o  out  1  lookup found a match (always 0 for writes).
- resp_index_o  out  IDXW  row matched or row written.
- resp_replaced_o  out  1  write overwrote a valid row.
- row_write_enable_o  out  ROWS  one-hot write enable to the rows.
- row_data_o  out  WIDTH  write data to all rows.
- row_compare_enable_o  out  1  compare strobe to all rows.
- row_compare_o  out  WIDTH  compare key to all rows.
- row_match_i  in  ROWS  per-row full-width match.
- row_valid_i  in  ROWS  per-row "has been written" flag.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, victim pointer=0, all outputs 0, except req_ready_o=0 while reset is asserted. This holds even mid-operation: any in-flight request and any pending response are dropped with no partial write.
- FSM states: IDLE, WRITE, COMPARE, RESP.
- IDLE
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: capture the request type and req_data_i into a request register, then go to WRITE or COMPARE.
  - req_ready_o=0 in every other state, so only one request is in flight.
- WRITE (exactly 1 cycle)
  - Target row = lowest index with row_valid_i=0.
  - If all rows are valid: target row = victim pointer, resp_replaced=1, and the victim pointer increments, wrapping ROWS-1 -> 0.
  - The victim pointer does not move when a free row exists.
  - Drives row_write_enable_o one-hot on the target row and row_data_o = captured data, then goes to RESP.
- COMPARE (MATCH_LAT+1 cycles)
  - row_compare_enable_o=1 and row_compare_o = captured key are held for the whole state.
  - On the final cycle, sample hits = row_match_i & row_valid_i.
  - hit = |hits; index = lowest set bit of hits, or 0 when there is no hit. Then go to RESP.
- RESP
  - resp_valid_o=1; all resp_* outputs are stable until resp_ready_i.
  - On resp_valid_o & resp_ready_i: go to IDLE.
  - Back-pressure may last indefinitely; no row signals are driven during RESP.
- Latency (resp_ready_i held high)
  - Write: accept in cycle N, row write in N+1, resp_valid_o in N+2.
  - Lookup: resp_valid_o in N+2+MATCH_LAT.
  - Next accept at the earliest 1 cycle after the response handshake.
- Row signals: row_write_enable_o and row_compare_enable_o are never high in the same cycle, and both are 0 outside WRITE/COMPARE. row_data_o and row_compare_o hold their last value when idle.
- Duplicate keys: writes do not de-duplicate. A lookup on duplicated data reports the lowest matching index.
- Rows with row_valid_i=0 never produce a hit, even if row_match_i is set.

Test Plan:
- Reset, then write 0xDEADBEEF -> row_write_enable_o=8'b0000_0001 one cycle after accept; response write=1, index=0, replaced=0, resp_valid_o 2 cycles after accept.
- Write rows 0..7 with 0x10..0x17, then lookup 0x15 -> hit=1, index=5. Lookup 0x99 -> hit=0, index=0.
- Array full, 3 further writes -> indices 0,1,2 with replaced=1; victim pointer reaches 3. Eleven full writes in total -> pointer wraps 7 -> 0.
- Write 0xAA to rows 2 and 6 (rows 0,1,3,4,5,7 hold other values), lookup 0xAA -> index=2. With row_valid_i[2] forced low and row_match_i[2] still set -> index=6.
- Hold resp_ready_i=0 for 10 cycles -> resp_valid_o stays 1 with stable fields; req_ready_o=0 throughout; no row enables asserted.
- Assert reset_n low mid-COMPARE (MATCH_LAT=2) -> all outputs 0 immediately; no response emitted; after release, a write goes to row 0 when row_valid_i=0.
